// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: oversampled SSD1306 4-wire SPI receiver with command decode
// and framebuffer write generation using SSD1306 addressing and auto-increment.
module ssd1306_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 4,
    localparam int COL_BITS   = $clog2(COLS),
    localparam int PAGE_BITS  = $clog2(PAGES)
) (
    input  logic                          clk_in,
    input  logic                          resetn_in,
    input  logic                          spi_sclk_in,
    input  logic                          spi_mosi_in,
    input  logic                          spi_csn_in,
    input  logic                          oled_dc_in,
    input  logic                          oled_rstn_in,
    output logic                          byte_valid_out,
    output logic [7:0]                    byte_out,
    output logic                          byte_is_data_out,
    output logic                          fb_we_out,
    output logic [PAGE_BITS+COL_BITS-1:0] fb_addr_out,
    output logic [7:0]                    fb_data_out,
    output logic                          display_on_out,
    output logic [7:0]                    contrast_out,
    output logic                          charge_pump_out,
    output logic                          cmd_error_out
);
    localparam logic [COL_BITS-1:0]  COL_MAX  = COL_BITS'(COLS - 1);
    localparam logic [PAGE_BITS-1:0] PAGE_MAX = PAGE_BITS'(PAGES - 1);
    // Synchroniser lanes {rstn, dc, csn, mosi, sclk}; panel reset starts asserted.
    localparam logic [4:0] SYNC_RST = 5'b00100;

    typedef enum logic [1:0] {S_OPCODE, S_ARG1, S_ARG2} state_e;

    typedef struct packed {
        logic [1:0]                    mode;
        logic [COL_BITS-1:0]           col;
        logic [COL_BITS-1:0]           col_lo;
        logic [COL_BITS-1:0]           col_hi;
        logic [PAGE_BITS-1:0]          page;
        logic [PAGE_BITS-1:0]          page_lo;
        logic [PAGE_BITS-1:0]          page_hi;
        logic [7:0]                    op;
        logic [COL_BITS-1:0]           arg;
        logic                          disp;
        logic [7:0]                    contrast;
        logic                          cp;
        logic                          bv;
        logic [7:0]                    bval;
        logic                          dc;
        logic                          we;
        logic [PAGE_BITS+COL_BITS-1:0] addr;
        logic [7:0]                    data;
        logic                          err;
    } regs_t;

    localparam regs_t REGS_RST = '{mode: 2'b10, col_hi: COL_MAX, page_hi: PAGE_MAX,
                                   contrast: 8'h7F, default: '0};

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic rstn_s, dc_s, csn_s, mosi_s, sclk_s, srst, take;
    logic sclk_prev_q, rx_done_q, rx_dc_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [7:0] rx_byte_q;
    state_e state_q, state_d;
    regs_t r_q, r_d;
    logic col_wrap, page_wrap, is_arg, is_nop;
    logic [COL_BITS-1:0] col_inc;
    logic [PAGE_BITS-1:0] page_inc;

    always_ff @(posedge clk_in or negedge resetn_in)
        if (!resetn_in) sync_q <= {SYNC_STAGES{SYNC_RST}};
        else sync_q <= {sync_q[SYNC_STAGES-2:0], oled_rstn_in, oled_dc_in, spi_csn_in, spi_mosi_in, spi_sclk_in};

    assign {rstn_s, dc_s, csn_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];
    assign srst = !rstn_s;
    // A final bit arriving together with CSn release still completes its byte.
    assign take = sclk_s && !sclk_prev_q && (!csn_s || bit_cnt_q == 3'd7);

    always_ff @(posedge clk_in or negedge resetn_in)
        if (!resetn_in || srst) begin
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            rx_done_q   <= 1'b0;
            rx_byte_q   <= 8'd0;
            rx_dc_q     <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            rx_done_q   <= take && bit_cnt_q == 3'd7;
            if (take) begin
                shift_q   <= {shift_q[5:0], mosi_s};
                bit_cnt_q <= csn_s ? 3'd0 : bit_cnt_q + 3'd1;
            end else if (csn_s) begin
                bit_cnt_q <= 3'd0;
            end
            if (take && bit_cnt_q == 3'd7) begin
                rx_byte_q <= {shift_q, mosi_s};
                rx_dc_q   <= dc_s;
            end
        end

    assign is_arg = rx_byte_q inside {8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB,
                                      8'h20, 8'h21, 8'h22};
    assign is_nop = rx_byte_q inside {[8'h40:8'h7F], 8'hA0, 8'hA1, [8'hA4:8'hA7], 8'hC0, 8'hC8, 8'hE3};
    assign col_wrap  = r_q.col == r_q.col_hi;
    assign page_wrap = r_q.page == r_q.page_hi;
    assign col_inc   = col_wrap ? r_q.col_lo : r_q.col + COL_BITS'(1);
    assign page_inc  = page_wrap ? r_q.page_lo : r_q.page + PAGE_BITS'(1);

    always_ff @(posedge clk_in or negedge resetn_in)
        if (!resetn_in) begin
            state_q <= S_OPCODE;
            r_q     <= REGS_RST;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        r_d.bv  = 1'b0;
        r_d.we  = 1'b0;
        r_d.err = 1'b0;
        if (rx_done_q) begin
            r_d.bv   = 1'b1;
            r_d.bval = rx_byte_q;
            r_d.dc   = rx_dc_q;
            if (rx_dc_q) begin
                r_d.err  = state_q != S_OPCODE;
                state_d  = S_OPCODE;
                r_d.we   = 1'b1;
                r_d.addr = {r_q.page, r_q.col};
                r_d.data = rx_byte_q;
                // Mode 00 horizontal, 01 vertical, 10 page.
                r_d.col  = (r_q.mode != 2'b01 || page_wrap) ? col_inc : r_q.col;
                r_d.page = r_q.mode == 2'b00 ? (col_wrap ? page_inc : r_q.page)
                         : r_q.mode == 2'b01 ? page_inc : r_q.page;
            end else if (state_q == S_OPCODE) begin
                r_d.op = rx_byte_q;
                if (rx_byte_q[7:1] == 7'h57) r_d.disp = rx_byte_q[0];
                else if (rx_byte_q[7:4] == 4'h0) r_d.col[3:0] = rx_byte_q[3:0];
                else if (rx_byte_q[7:4] == 4'h1) r_d.col[COL_BITS-1:4] = rx_byte_q[COL_BITS-5:0];
                else if (rx_byte_q[7:3] == 5'b10110) r_d.page = rx_byte_q[PAGE_BITS-1:0];
                else if (is_arg) state_d = S_ARG1;
                else if (!is_nop) r_d.err = 1'b1;
            end else if (state_q == S_ARG1) begin
                r_d.arg = rx_byte_q[COL_BITS-1:0];
                state_d = (r_q.op == 8'h21 || r_q.op == 8'h22) ? S_ARG2 : S_OPCODE;
                if (r_q.op == 8'h81) r_d.contrast = rx_byte_q;
                if (r_q.op == 8'h8D) r_d.cp = rx_byte_q[2];
                if (r_q.op == 8'h20 && rx_byte_q[1:0] != 2'b11) r_d.mode = rx_byte_q[1:0];
            end else begin
                state_d = S_OPCODE;
                if (r_q.op == 8'h21) begin
                    r_d.col_lo = r_q.arg;
                    r_d.col_hi = rx_byte_q[COL_BITS-1:0];
                    r_d.col    = r_q.arg;
                end
                if (r_q.op == 8'h22) begin
                    r_d.page_lo = r_q.arg[PAGE_BITS-1:0];
                    r_d.page_hi = rx_byte_q[PAGE_BITS-1:0];
                    r_d.page    = r_q.arg[PAGE_BITS-1:0];
                end
            end
        end
        if (srst) begin
            state_d = S_OPCODE;
            r_d     = REGS_RST;
        end
    end

    assign byte_valid_out   = r_q.bv;
    assign byte_out         = r_q.bval;
    assign byte_is_data_out = r_q.dc;
    assign fb_we_out        = r_q.we;
    assign fb_addr_out      = r_q.addr;
    assign fb_data_out      = r_q.data;
    assign display_on_out   = r_q.disp;
    assign contrast_out     = r_q.contrast;
    assign charge_pump_out  = r_q.cp;
    assign cmd_error_out    = r_q.err;
endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// tb_ssd1306_spi_receiver: random and directed SPI traffic checked against a
// queue-based SSD1306 behavioural model, plus literal expectations.
module tb_ssd1306_spi_receiver;
    localparam int SS = 2, COLS = 128, PAGES = 4;

    logic clk = 1'b0, resetn = 1'b0, sclk = 1'b0, mosi = 1'b0, csn = 1'b1, dc = 1'b0, rstn = 1'b1;
    logic bv, is_data, fb_we, disp, cp, err;
    logic [7:0] bout, fb_data, contrast;
    logic [8:0] fb_addr;

    ssd1306_spi_receiver #(.SYNC_STAGES(SS), .COLS(COLS), .PAGES(PAGES)) dut (
        .clk_in(clk), .resetn_in(resetn), .spi_sclk_in(sclk), .spi_mosi_in(mosi),
        .spi_csn_in(csn), .oled_dc_in(dc), .oled_rstn_in(rstn),
        .byte_valid_out(bv), .byte_out(bout), .byte_is_data_out(is_data),
        .fb_we_out(fb_we), .fb_addr_out(fb_addr), .fb_data_out(fb_data),
        .display_on_out(disp), .contrast_out(contrast), .charge_pump_out(cp),
        .cmd_error_out(err));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0, miscompares = 0, n_bv = 0, n_err = 0;
    int wlog[$];
    logic [7:0] dlog[$];

    typedef struct {
        logic [7:0] b, data, contrast;
        bit dc, we, err, disp, cp;
        int addr, edge_cyc;
    } exp_t;
    exp_t expq[$];

    int m_mode, m_col, m_page, m_clo, m_chi, m_plo, m_phi, m_nargs;
    logic [7:0] m_op, m_arg, m_contrast;
    bit m_disp, m_cp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 2; m_col = 0; m_page = 0; m_clo = 0; m_chi = COLS - 1;
        m_plo = 0; m_phi = PAGES - 1; m_nargs = 0; m_op = 0; m_arg = 0;
        m_contrast = 8'h7F; m_disp = 0; m_cp = 0;
    endtask

    task automatic advance();
        if (m_mode == 2) begin
            m_col = (m_col == m_chi) ? m_clo : (m_col + 1) % COLS;
        end else if (m_mode == 0) begin
            if (m_col == m_chi) begin
                m_col = m_clo;
                m_page = (m_page == m_phi) ? m_plo : (m_page + 1) % PAGES;
            end else m_col = (m_col + 1) % COLS;
        end else begin
            if (m_page == m_phi) begin
                m_page = m_plo;
                m_col = (m_col == m_chi) ? m_clo : (m_col + 1) % COLS;
            end else m_page = (m_page + 1) % PAGES;
        end
    endtask

    task automatic model_byte(input bit d, input logic [7:0] b);
        exp_t e;
        int v;
        v = int'(b);
        e.b = b; e.dc = d; e.we = d; e.err = 0; e.addr = 0; e.data = b; e.edge_cyc = cyc;
        if (d) begin
            e.err = m_nargs != 0;
            m_nargs = 0;
            e.addr = m_page * COLS + m_col;
            advance();
        end else if (m_nargs == 0) begin
            if (v == 'hAE || v == 'hAF) m_disp = (v == 'hAF);
            else if (v < 16) m_col = (m_col / 16) * 16 + v;
            else if (v < 32) m_col = ((v - 16) % (COLS / 16)) * 16 + m_col % 16;
            else if (v >= 'hB0 && v <= 'hB7) m_page = (v - 'hB0) % PAGES;
            else if ((v >= 'h40 && v <= 'h7F) || v == 'hA0 || v == 'hA1 || (v >= 'hA4 && v <= 'hA7)
                     || v == 'hC0 || v == 'hC8 || v == 'hE3) ;
            else if (v == 'h21 || v == 'h22) begin m_op = b; m_nargs = 2; end
            else if (v == 'h81 || v == 'h8D || v == 'hA8 || v == 'hD3 || v == 'hD5 || v == 'hD9
                     || v == 'hDA || v == 'hDB || v == 'h20) begin m_op = b; m_nargs = 1; end
            else e.err = 1;
        end else if (m_nargs == 2) begin
            m_arg = b;
            m_nargs = 1;
        end else begin
            m_nargs = 0;
            if (m_op == 8'h81) m_contrast = b;
            if (m_op == 8'h8D) m_cp = b[2];
            if (m_op == 8'h20 && v % 4 != 3) m_mode = v % 4;
            if (m_op == 8'h21) begin m_clo = int'(m_arg) % COLS; m_chi = v % COLS; m_col = m_clo; end
            if (m_op == 8'h22) begin m_plo = int'(m_arg) % PAGES; m_phi = v % PAGES; m_page = m_plo; end
        end
        e.disp = m_disp; e.contrast = m_contrast; e.cp = m_cp;
        expq.push_back(e);
    endtask

    always @(negedge clk) if (resetn) begin
        if (bv) begin
            n_bv++;
            if (err) n_err++;
            if (fb_we) begin wlog.push_back(int'(fb_addr)); dlog.push_back(fb_data); end
            if (expq.size() == 0) chk("unexpected_byte", {24'd0, bout}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = expq.pop_front();
                chk("byte", bout, e.b);
                chk("is_data", is_data, e.dc);
                chk("latency", cyc - e.edge_cyc, SS + 2);
                chk("fb_we", fb_we, e.we);
                chk("cmd_error", err, e.err);
                chk("display_on", disp, e.disp);
                chk("contrast", contrast, e.contrast);
                chk("charge_pump", cp, e.cp);
                if (e.we) begin
                    chk("fb_addr", fb_addr, e.addr);
                    chk("fb_data", fb_data, e.data);
                end
            end
        end else chk("idle_pulses", {bv, fb_we, err}, 0);
    end

    task automatic send_byte(input bit d, input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); mosi = b[7-i]; dc = d;
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            if (i == 7) model_byte(d, b);
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] b); send_byte(1'b0, b, 8); endtask
    task automatic dat(input logic [7:0] b); send_byte(1'b1, b, 8); endtask
    task automatic drain(); repeat (12) @(negedge clk); endtask
    task automatic cs_cycle();
        @(negedge clk); csn = 1'b1; repeat (6) @(negedge clk); csn = 1'b0; repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_display"}, disp, 0);
        chk({tag, "_contrast"}, contrast, 8'h7F);
        chk({tag, "_charge_pump"}, cp, 0);
        chk({tag, "_byte"}, bout, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_data"}, fb_data, 0);
    endtask

    task automatic panel_reset();
        drain();
        @(negedge clk); rstn = 1'b0;
        repeat (6) @(negedge clk);
        model_reset();
        rstn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    logic [7:0] picks[24] = '{8'hAE, 8'hAF, 8'h05, 8'h13, 8'hB1, 8'hB6, 8'h40, 8'hA1, 8'hC8, 8'hE3,
                              8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hDA, 8'h20, 8'h20, 8'h21, 8'h22,
                              8'hFF, 8'h30, 8'h0A, 8'h1F};
    int exp_h[5] = '{'h07E, 'h07F, 'h0FE, 'h0FF, 'h07E};

    initial begin
        int nb, ne, r;
        model_reset();
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_values("por");
        csn = 1'b0;
        repeat (3) @(negedge clk);

        cmd(8'hAF); drain();
        chk("af_byte", bout, 8'hAF);
        chk("af_is_data", is_data, 0);
        chk("af_display", disp, 1);
        chk("af_pulses", n_bv, 1);

        cmd(8'h81); cmd(8'h3C); cmd(8'h8D); cmd(8'h14); drain();
        chk("contrast_3c", contrast, 8'h3C);
        chk("charge_pump_on", cp, 1);
        chk("no_errors", n_err, 0);

        cmd(8'h20); cmd(8'h00); cmd(8'h21); cmd(8'h7E); cmd(8'h7F); cmd(8'h22); cmd(8'h00); cmd(8'h01);
        drain();
        wlog.delete(); dlog.delete();
        for (int i = 0; i < 5; i++) dat(8'($urandom));
        drain();
        chk("horiz_writes", wlog.size(), 5);
        if (wlog.size() == 5) for (int i = 0; i < 5; i++) chk("horiz_addr", wlog[i], exp_h[i]);

        cmd(8'h20); cmd(8'h02); cmd(8'h21); cmd(8'h00); cmd(8'h7F); cmd(8'hB2); cmd(8'h0F); cmd(8'h17);
        drain();
        wlog.delete(); dlog.delete();
        dat(8'hAA); dat(8'h11); drain();
        chk("page_writes", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("page_addr0", wlog[0], 'h17F);
            chk("page_data0", dlog[0], 8'hAA);
            chk("page_addr1", wlog[1], 'h100);
        end

        nb = n_bv;
        send_byte(1'b0, 8'hFF, 5);
        cs_cycle();
        cmd(8'hAE); drain();
        chk("abort_pulses", n_bv - nb, 1);
        chk("abort_byte", bout, 8'hAE);
        chk("abort_display", disp, 0);
        ne = n_err;
        cmd(8'hFF); drain();
        chk("unknown_err", n_err - ne, 1);

        ne = n_err;
        wlog.delete(); dlog.delete();
        cmd(8'h81); dat(8'h55); drain();
        chk("pending_err", n_err - ne, 1);
        chk("pending_writes", wlog.size(), 1);
        if (wlog.size() == 1) chk("pending_data", dlog[0], 8'h55);
        chk("pending_contrast", contrast, 8'h3C);

        panel_reset();
        check_reset_values("panel");

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin send_byte(1'($urandom), 8'($urandom), $urandom_range(1, 7)); cs_cycle(); end
            else if (r < 6) cs_cycle();
            else if (r == 99) panel_reset();
            r = $urandom_range(0, 9);
            if (r < 4) dat(8'($urandom));
            else if (r < 8) cmd(picks[$urandom_range(0, 23)]);
            else cmd(8'($urandom));
        end
        drain();
        chk("model_queue_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
